// File: rtl/accel_spi_slave_pkg.sv
// Shared constants, FSM state encoding and register reset values for the
// ADXL362-style SPI responder model.
package accel_spi_slave_pkg;

    // Command bytes understood by the responder
    localparam logic [7:0] CMD_WRITE   = 8'h0A;
    localparam logic [7:0] CMD_READ    = 8'h0B;

    // STATUS register address (read-to-clear when that build option is on)
    localparam logic [5:0] ADDR_STATUS = 6'h0B;

    // Addresses below this limit are read-only from the SPI side
    localparam logic [5:0] RO_LIMIT    = 6'h04;

    // Identification registers 0x00-0x03
    localparam logic [7:0] ID_DEVID_AD  = 8'hAD;
    localparam logic [7:0] ID_DEVID_MST = 8'h1D;
    localparam logic [7:0] ID_PARTID    = 8'hF2;
    localparam logic [7:0] ID_REVID     = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_IGNORE  = 3'd5
    } state_t;

    // Power-on content of one register-file entry
    function automatic logic [7:0] reg_reset_value(input int idx);
        case (idx)
            0:       return ID_DEVID_AD;
            1:       return ID_DEVID_MST;
            2:       return ID_PARTID;
            3:       return ID_REVID;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/accel_spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses taken from the synchronized level against a one-cycle
// delayed copy. Pin-edge to pulse-consumer latency is SYNC_STAGES+1 clocks.
module accel_spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    // Shift the pin through the synchronizer chain and keep a delayed copy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_dly  <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/accel_spi_slave_model.sv
// SPI mode-0 responder emulating the ADXL362 register protocol: 64x8
// register file, 0x0A write / 0x0B read commands with auto-increment bursts.
// Optional build macro ACCEL_SPI_STATUS_RDCLR_EN makes register 0x0B
// read-to-clear and read-only from the SPI side.
//
// Handshake: none; host writes are single-cycle strobes (host_wr_en), SPI
// commits are reported by a one-cycle spi_wr_strobe with addr/data valid in
// the same cycle. o_dbg_state exposes the protocol FSM state.
module accel_spi_slave_model
    import accel_spi_slave_pkg::*;
#(
    parameter int REG_DEPTH   = 64,
    parameter int SYNC_STAGES = 2,
    localparam int AW         = $clog2(REG_DEPTH)
) (
    input  logic          s00_axi_aclk,
    input  logic          s00_axi_areset,
    input  logic          spi_cs_n,
    input  logic          spi_sclk,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    input  logic          host_wr_en,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wr_data,
    output logic [7:0]    host_rd_data,
    output logic          spi_wr_strobe,
    output logic [AW-1:0] spi_wr_addr,
    output logic [7:0]    spi_wr_data,
    output logic          frame_err,
    output logic [2:0]    o_dbg_state
);

    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_rx_sr;
    logic [7:0]    r_tx_sr;
    logic [AW-1:0] r_addr;
    logic          r_wr_flag;
    logic          r_miso;
    logic          r_wr_strobe;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_frame_err;
    logic [7:0]    r_regs [REG_DEPTH];

    logic [7:0]    w_rx_next;
    logic          w_byte_done;
    logic          w_in_frame;
    logic          w_writable;
    logic          w_spi_we;
    logic          w_rdclr;
    logic [AW-1:0] w_addr_inc;

    // cs_n idles high, so its synchronizer resets high to avoid a fake fall
    accel_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk(s00_axi_aclk), .i_rst(s00_axi_areset), .i_din(spi_cs_n),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    accel_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk(s00_axi_aclk), .i_rst(s00_axi_areset), .i_din(spi_sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    // mosi goes through the same depth so it lines up with the sclk edge pulse
    accel_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(s00_axi_aclk), .i_rst(s00_axi_areset), .i_din(spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sclk_lvl, w_mosi_rise, w_mosi_fall};

    assign w_rx_next   = {r_rx_sr[6:0], w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7) && !w_cs_rise;
    assign w_in_frame  = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                         (r_state == ST_WR_DATA) || (r_state == ST_RD_DATA);
    assign w_addr_inc  = r_addr + 1'b1;

`ifdef ACCEL_SPI_STATUS_RDCLR_EN
    assign w_writable = (r_addr >= RO_LIMIT) && (r_addr != ADDR_STATUS);
    assign w_rdclr    = (r_state == ST_RD_DATA) && w_byte_done && (r_addr == ADDR_STATUS);
`else
    assign w_writable = (r_addr >= RO_LIMIT);
    assign w_rdclr    = 1'b0;
`endif

    assign w_spi_we = (r_state == ST_WR_DATA) && w_byte_done && w_writable;

    // Protocol FSM: command/address decode, bit shifting, MISO drive, commits
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx_sr     <= 8'h00;
            r_tx_sr     <= 8'h00;
            r_addr      <= '0;
            r_wr_flag   <= 1'b0;
            r_miso      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_cs_rise) begin
                // Chip-select release always ends the frame; flag a partial byte
                r_state   <= ST_IDLE;
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
                if (w_in_frame && (r_bit_cnt != 3'd0)) begin
                    r_frame_err <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= ST_CMD;
                            r_bit_cnt <= 3'd0;
                            r_rx_sr   <= 8'h00;
                        end
                    end
                    ST_CMD, ST_ADDR, ST_WR_DATA, ST_RD_DATA: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_rx_sr   <= w_rx_next;
                        end
                        if ((r_state == ST_RD_DATA) && w_sclk_fall) begin
                            r_miso  <= r_tx_sr[7];
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                        end
                        if (w_byte_done) begin
                            case (r_state)
                                ST_CMD: begin
                                    if (w_rx_next == CMD_WRITE) begin
                                        r_state   <= ST_ADDR;
                                        r_wr_flag <= 1'b1;
                                    end else if (w_rx_next == CMD_READ) begin
                                        r_state   <= ST_ADDR;
                                        r_wr_flag <= 1'b0;
                                    end else begin
                                        r_state   <= ST_IGNORE;
                                    end
                                end
                                ST_ADDR: begin
                                    r_addr <= w_rx_next[AW-1:0];
                                    if (r_wr_flag) begin
                                        r_state <= ST_WR_DATA;
                                    end else begin
                                        r_state <= ST_RD_DATA;
                                        r_tx_sr <= r_regs[w_rx_next[AW-1:0]];
                                    end
                                end
                                ST_WR_DATA: begin
                                    if (w_writable) begin
                                        r_wr_strobe <= 1'b1;
                                        r_wr_addr   <= r_addr;
                                        r_wr_data   <= w_rx_next;
                                    end
                                    r_addr <= w_addr_inc;
                                end
                                default: begin
                                    // RD_DATA: advance the burst and preload the next byte
                                    r_addr  <= w_addr_inc;
                                    r_tx_sr <= r_regs[w_addr_inc];
                                end
                            endcase
                        end
                    end
                    default: begin
                        // IGNORE: wait for chip-select release with MISO low
                        r_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register file: host writes first, SPI commit last so SPI wins a same-address collision
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_regs[i] <= reg_reset_value(i);
            end
        end else begin
            if (w_rdclr) begin
                r_regs[ADDR_STATUS] <= 8'h00;
            end
            if (host_wr_en) begin
                r_regs[host_addr] <= host_wr_data;
            end
            if (w_spi_we) begin
                r_regs[r_addr] <= w_rx_next;
            end
        end
    end

    assign spi_miso      = r_miso & (r_state == ST_RD_DATA);
    assign spi_miso_oe   = ~w_cs_lvl;
    assign host_rd_data  = r_regs[host_addr];
    assign spi_wr_strobe = r_wr_strobe;
    assign spi_wr_addr   = r_wr_addr;
    assign spi_wr_data   = r_wr_data;
    assign frame_err     = r_frame_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_accel_spi_slave_model.sv
// Self-checking bench for accel_spi_slave_model: SPI master driver tasks,
// a strobe scoreboard, table-driven write/read vectors and hand sequences
// for ID read, bursts, abort, bad command, collisions and STATUS clearing.
module tb_accel_spi_slave_model;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_cs_n, spi_sclk, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       host_wr_en;
  logic [5:0] host_addr;
  logic [7:0] host_wr_data, host_rd_data;
  logic       spi_wr_strobe;
  logic [5:0] spi_wr_addr;
  logic [7:0] spi_wr_data;
  logic       frame_err;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int str_cnt = 0;
  logic [13:0] exp_q[$];
  logic [13:0] sb_exp;

  accel_spi_slave_model dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .host_wr_en(host_wr_en), .host_addr(host_addr),
    .host_wr_data(host_wr_data), .host_rd_data(host_rd_data),
    .spi_wr_strobe(spi_wr_strobe), .spi_wr_addr(spi_wr_addr),
    .spi_wr_data(spi_wr_data), .frame_err(frame_err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every SPI commit strobe must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && frame_err) fe_cnt++;
    if (!rst && spi_wr_strobe) begin
      str_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe_unexpected: got %0h=%0h expected none", spi_wr_addr, spi_wr_data);
      end else begin
        sb_exp = exp_q.pop_front();
        check("strobe", {18'h0, spi_wr_addr, spi_wr_data}, {18'h0, sb_exp});
      end
    end
  end

  // driver tasks
  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    host_addr = a; host_wr_data = d; host_wr_en = 1'b1;
    tick(1);
    host_wr_en = 1'b0;
  endtask

  task automatic host_peek(input logic [5:0] a, output logic [7:0] d);
    host_addr = a;
    #1 d = host_rd_data;
  endtask

  task automatic spi_begin;
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic spi_end;
    spi_sclk = 1'b0;
    tick(4);
    spi_cs_n = 1'b1;
    tick(6);
  endtask

  // Shift the top n bits of tx; optionally fire a host write in the exact
  // cycle the responder acts on the 8th rising edge (3 clocks after the pin).
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx,
                          input logic coll, input logic [5:0] ca, input logic [7:0] cd);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_sclk = 1'b0; spi_mosi = tx[i];
      tick(4);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      if (coll && i == 0) begin
        tick(2);
        host_addr = ca; host_wr_data = cd; host_wr_en = 1'b1;
        tick(1);
        host_wr_en = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx, 1'b0, 6'h0, 8'h0);
  endtask

  task automatic spi_read1(input logic [5:0] a, output logic [7:0] d);
    logic [7:0] dummy;
    spi_begin();
    spi_byte(8'h0B, dummy);
    spi_byte({2'b00, a}, dummy);
    spi_byte(8'h00, d);
    spi_end();
  endtask

  task automatic spi_write1(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    spi_begin();
    spi_byte(8'h0A, dummy);
    spi_byte({2'b00, a}, dummy);
    spi_byte(d, dummy);
    spi_end();
  endtask

  typedef struct {
    logic [5:0] addr;
    logic [7:0] val;
  } rvec_t;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    logic       strobe;
    logic [7:0] rd;
  } wvec_t;

  rvec_t rv[7];
  wvec_t wv[6];

  initial begin
    logic [7:0] rx, v;
    logic [7:0] id_exp [4];
    int fe0, st0;

    rv[0] = '{6'h00, 8'hAD}; rv[1] = '{6'h01, 8'h1D}; rv[2] = '{6'h02, 8'hF2};
    rv[3] = '{6'h03, 8'h01}; rv[4] = '{6'h04, 8'h00}; rv[5] = '{6'h0B, 8'h00};
    rv[6] = '{6'h3F, 8'h00};

    wv[0] = '{6'h04, 8'h12, 1'b1, 8'h12};
    wv[1] = '{6'h02, 8'h99, 1'b0, 8'hF2};
    wv[2] = '{6'h3F, 8'hC3, 1'b1, 8'hC3};
    wv[3] = '{6'h2A, 8'hA5, 1'b1, 8'hA5};
    wv[4] = '{6'h01, 8'h00, 1'b0, 8'h1D};
`ifdef ACCEL_SPI_STATUS_RDCLR_EN
    wv[5] = '{6'h0B, 8'h5A, 1'b0, 8'h00};
`else
    wv[5] = '{6'h0B, 8'h5A, 1'b1, 8'h5A};
`endif

    id_exp[0] = 8'hAD; id_exp[1] = 8'h1D; id_exp[2] = 8'hF2; id_exp[3] = 8'h01;

    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    host_wr_en = 1'b0; host_addr = 6'h0; host_wr_data = 8'h0;
    tick(4);
    rst = 1'b0;
    tick(2);

    // reset state
    check("rst_miso", spi_miso, 0);
    check("rst_miso_oe", spi_miso_oe, 0);
    check("rst_strobe", spi_wr_strobe, 0);
    check("rst_wr_addr", spi_wr_addr, 0);
    check("rst_wr_data", spi_wr_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_state", dbg_state, 0);
    for (int i = 0; i < 7; i++) begin
      host_peek(rv[i].addr, v);
      check($sformatf("rst_reg_%0h", rv[i].addr), v, rv[i].val);
    end

    // read ID burst
    fe0 = fe_cnt;
    spi_begin();
    check("miso_oe_active", spi_miso_oe, 1);
    spi_byte(8'h0B, rx);
    check("id_cmd_miso", rx, 0);
    spi_byte(8'h00, rx);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      check($sformatf("id_byte%0d", i), rx, id_exp[i]);
    end
    spi_end();
    check("id_no_frame_err", fe_cnt - fe0, 0);
    check("miso_oe_idle", spi_miso_oe, 0);

    // write burst wrapping past 0x3F into read-only 0x00
    st0 = str_cnt;
    exp_q.push_back({6'h3E, 8'h55});
    exp_q.push_back({6'h3F, 8'h66});
    spi_begin();
    spi_byte(8'h0A, rx); spi_byte(8'h3E, rx);
    spi_byte(8'h55, rx); spi_byte(8'h66, rx); spi_byte(8'h77, rx);
    spi_end();
    check("burst_strobes", str_cnt - st0, 2);
    host_peek(6'h3F, v); check("burst_3f", v, 8'h66);
    host_peek(6'h3E, v); check("burst_3e", v, 8'h55);
    host_peek(6'h00, v); check("burst_ro_00", v, 8'hAD);

    // abort mid-byte
    fe0 = fe_cnt; st0 = str_cnt;
    spi_begin();
    spi_byte(8'h0A, rx); spi_byte(8'h10, rx);
    spi_bits(8'hFF, 4, rx, 1'b0, 6'h0, 8'h0);
    spi_end();
    check("abort_frame_err", fe_cnt - fe0, 1);
    check("abort_no_strobe", str_cnt - st0, 0);
    check("abort_state_idle", dbg_state, 0);
    host_peek(6'h10, v); check("abort_reg10", v, 8'h00);
    exp_q.push_back({6'h10, 8'h3C});
    spi_write1(6'h10, 8'h3C);
    host_peek(6'h10, v); check("after_abort_reg10", v, 8'h3C);

    // table: SPI write then SPI read back
    for (int i = 0; i < 6; i++) begin
      st0 = str_cnt;
      if (wv[i].strobe) exp_q.push_back({wv[i].addr, wv[i].data});
      spi_write1(wv[i].addr, wv[i].data);
      check($sformatf("vec%0d_strobes", i), str_cnt - st0, {31'h0, wv[i].strobe});
      spi_read1(wv[i].addr, rx);
      check($sformatf("vec%0d_read", i), rx, wv[i].rd);
    end

    // read burst wrapping 0x3F -> 0x00
    spi_begin();
    spi_byte(8'h0B, rx); spi_byte(8'h3F, rx);
    spi_byte(8'h00, rx); check("rdwrap_3f", rx, 8'hC3);
    spi_byte(8'h00, rx); check("rdwrap_00", rx, 8'hAD);
    spi_end();

    // unknown command: ignored, MISO low, byte-aligned release is clean
    fe0 = fe_cnt; st0 = str_cnt;
    spi_begin();
    spi_byte(8'h55, rx); check("badcmd_miso0", rx, 0);
    check("badcmd_state", dbg_state, 5);
    spi_byte(8'hFF, rx); check("badcmd_miso1", rx, 0);
    spi_byte(8'hFF, rx); check("badcmd_miso2", rx, 0);
    spi_end();
    check("badcmd_no_frame_err", fe_cnt - fe0, 0);
    check("badcmd_no_strobe", str_cnt - st0, 0);

    // collision: same address, SPI wins
    exp_q.push_back({6'h20, 8'hBB});
    spi_begin();
    spi_byte(8'h0A, rx); spi_byte(8'h20, rx);
    spi_bits(8'hBB, 8, rx, 1'b1, 6'h20, 8'hAA);
    spi_end();
    host_peek(6'h20, v); check("coll_same", v, 8'hBB);

    // collision: different addresses, both land
    exp_q.push_back({6'h21, 8'hCC});
    spi_begin();
    spi_byte(8'h0A, rx); spi_byte(8'h21, rx);
    spi_bits(8'hCC, 8, rx, 1'b1, 6'h22, 8'h77);
    spi_end();
    host_peek(6'h21, v); check("coll_diff_spi", v, 8'hCC);
    host_peek(6'h22, v); check("coll_diff_host", v, 8'h77);

    // host may write read-only registers
    host_write(6'h03, 8'h5E);
    host_peek(6'h03, v); check("host_ro_write", v, 8'h5E);

    // STATUS read behaviour
    host_write(6'h0B, 8'h41);
    spi_read1(6'h0B, rx); check("status_read1", rx, 8'h41);
    spi_read1(6'h0B, rx);
`ifdef ACCEL_SPI_STATUS_RDCLR_EN
    check("status_read2", rx, 8'h00);
`else
    check("status_read2", rx, 8'h41);
`endif

    tick(4);
    check("sb_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_spi_slave_model.md
Name: accel_spi_slave_model

Overview:
- SPI mode-0 responder that emulates the ADXL362-style register protocol of the Pmod accelerometer; it is the far end of the accelerometer SPI master.
- Used as the loopback/bring-up target on the ja Pmod pins and as the bench model for the master IP.
- Holds a 64x8 register file that the master reads and writes over SPI and the host side preloads with sample data.
- All SPI inputs are oversampled in the system clock domain.

Parameters:
- REG_DEPTH, 64, register-file entries; address width is log2 of this (6).
- SYNC_STAGES, 2, synchronizer flops on cs_n/sclk/mosi.

Ports:
- s00_axi_aclk  in  1  system clock; must run at least 8x the SPI sclk frequency.
- s00_axi_areset  in  1  reset; synchronous, active-high.
- spi_cs_n  in  1  chip select from master, active-low.
- spi_sclk  in  1  SPI clock, idle low.
- spi_mosi  in  1  master data out.
- spi_miso  out  1  responder data out.
- spi_miso_oe  out  1  output enable for the MISO pad; high while cs_n is low.
- host_wr_en  in  1  host register write strobe.
- host_addr  in  6  host write/read address.
- host_wr_data  in  8  host write data.
- host_rd_data  out  8  combinational read of regfile[host_addr].
- spi_wr_strobe  out  1  one-cycle pulse when an SPI write commits.
- spi_wr_addr  out  6  address of the committed SPI write.
- spi_wr_data  out  8  data of the committed SPI write.
- frame_err  out  1  one-cycle pulse when cs_n deasserts mid-byte.

Behaviour:
- Synchronization: cs_n, sclk and mosi each pass SYNC_STAGES flops. Rise/fall detect uses the synchronized value against a one-cycle delay. Edge-to-action latency is 3 clocks.
- Reset (synchronous, active-high):
  - Outputs: spi_miso=0, spi_miso_oe=0, spi_wr_strobe=0, spi_wr_addr=0, spi_wr_data=0, frame_err=0.
  - Internal: state=IDLE, bit_cnt=0.
  - Regfile: 0x00=0xAD, 0x01=0x1D, 0x02=0xF2, 0x03=0x01, all others 0x00.
  - Reset mid-transfer aborts the transfer with no commit and no frame_err.
- FSM states: IDLE, CMD, ADDR, WR_DATA, RD_DATA, IGNORE.
  - IDLE -> CMD on synced cs_n fall; clears bit_cnt and rx_sr.
  - Every state: synced cs_n rise -> IDLE. frame_err pulses if the state is CMD/ADDR/WR_DATA/RD_DATA and bit_cnt != 0.
  - Bits are sampled on the sclk rising edge, MSB first. bit_cnt is 3 bits and wraps at 8.
  - CMD, after the 8th bit: 0x0A -> ADDR with write flag, 0x0B -> ADDR with read flag, anything else -> IGNORE.
  - ADDR, after the 8th bit: addr = rx[5:0] (bits 7:6 ignored). Write flag -> WR_DATA. Read flag -> RD_DATA, with tx_sr loaded from regfile[addr] on that same cycle.
  - WR_DATA, after each 8th bit: if addr >= 0x04, regfile[addr] = byte and spi_wr_strobe pulses with addr/data. Addresses 0x00-0x03 are read-only: the write is dropped and there is no strobe. Then addr = addr+1 mod 64.
  - RD_DATA, on each sclk fall: spi_miso = tx_sr[7], then tx_sr shifts left. After the 8th rising edge: addr = addr+1 mod 64 and tx_sr = regfile[addr+1]. A burst past 0x3F wraps to 0x00.
  - IGNORE: hold until cs_n rises; MISO = 0.
- MISO: 0 in IDLE/CMD/ADDR/IGNORE. spi_miso_oe = NOT synced cs_n.
- Write collision: an SPI commit and a host write in the same cycle to the same address -> the SPI value wins. Different addresses -> both apply. The host may write the read-only registers.
- sclk edges while cs_n is high are ignored.

Optional Feature:
- Macro ACCEL_SPI_STATUS_RDCLR_EN.
- Defined:
  - Register 0x0B (STATUS) is read-to-clear. When an SPI read byte sourced from 0x0B completes (8th rising edge), 0x0B clears to 0x00 unless a host write to 0x0B occurs in the same cycle; in that case the host value wins.
  - SPI writes to 0x0B are dropped with no strobe.
- Undefined: 0x0B is an ordinary read/write register.

Decomposition:
- Package accel_spi_slave_pkg: CMD_WRITE=8'h0A, CMD_READ=8'h0B, ADDR_STATUS=6'h0B, RO_LIMIT=6'h04, the reset-default ID constants, and the FSM state enum.
- Sub-module accel_spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs; instantiated once per input.

Test Plan:
- Read ID: cs low, send 0x0B 0x00, clock 4 bytes -> MISO returns 0xAD,0x1D,0xF2,0x01; frame_err stays 0.
- Write burst: send 0x0A 0x3E 0x55 0x66 0x77 -> strobes at 0x3E=0x55, 0x3F=0x66, 0x00 dropped (read-only, no strobe); host_rd_data at 0x3F = 0x66.
- Abort: send 0x0A 0x10, then 4 data bits, then raise cs -> frame_err pulses once; regfile[0x10] unchanged; the next transfer decodes normally.
- Bad command: send 0x55 then 16 clocks -> MISO=0 throughout, no strobe, no frame_err on a byte-aligned cs rise.
- Collision: host writes 0x20=0xAA in the same cycle an SPI write commits 0x20=0xBB -> regfile[0x20]=0xBB.
- RDCLR on: host writes 0x0B=0x41, then SPI reads 0x0B twice in separate transfers -> 0x41 then 0x00. RDCLR off: 0x41 both times.
